// File: rtl/cpu16_pkg.sv
// Shared cpu16 definitions: opcode constants, frame field widths and the
// program-loader state encoding.
package cpu16_pkg;

  localparam int unsigned MemBytesDef = 64;

  // Frame and write-port field widths.
  localparam int unsigned LenW  = 8;
  localparam int unsigned DataW = 8;
  localparam int unsigned AddrW = 16;

  // ALU opcodes, held over from the existing core.
  localparam logic [3:0] ISADD = 4'h0;
  localparam logic [3:0] ISSUB = 4'h1;
  localparam logic [3:0] ISAND = 4'h2;
  localparam logic [3:0] ISOR  = 4'h3;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } ld_state_e;

endpackage

// File: rtl/cpu16_loader.sv
// Instruction-memory writer: takes a LEN/data/checksum frame over valid/ready,
// writes data bytes with one cycle of latency and releases the CPU on a good sum.
module cpu16_loader
  import cpu16_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MemBytesDef,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic [DataW-1:0] RX_DATA,
  input  logic             RX_VALID,
  output logic             RX_READY,
  output logic             WE,
  output logic [AddrW-1:0] WADDR,
  output logic [DataW-1:0] WDATA,
  output logic             BUSY,
  output logic             RUN,
  output logic             ERR
);

  ld_state_e        state_q, state_d;
  logic [LenW-1:0]  idx_q, idx_d;
  logic [LenW-1:0]  len_q, len_d;
  logic [DataW-1:0] sum_q, sum_d;
  logic             we_q, we_d;
  logic [AddrW-1:0] waddr_q, waddr_d;
  logic [DataW-1:0] wdata_q, wdata_d;

  logic             xfer;
  logic             len_bad;
  logic [DataW-1:0] csum_total;

  assign xfer       = RX_VALID & RX_READY;
  assign len_bad    = (RX_DATA == '0) || RX_DATA[0] || (32'(RX_DATA) > MEM_BYTES);
  assign csum_total = sum_q + RX_DATA;

  // State register.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: if (START) state_d = StLen;
      StLen:  if (xfer) state_d = len_bad ? StErr : StData;
      StData: if (xfer && (idx_q == len_q - 8'd1)) state_d = StCsum;
      StCsum: if (xfer) state_d = (csum_total == '0) ? StDone : StErr;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    RX_READY = 1'b0;
    BUSY     = 1'b0;
    RUN      = 1'b0;
    ERR      = 1'b0;
    unique case (state_q)
      StLen, StData, StCsum: begin
        RX_READY = 1'b1;
        BUSY     = 1'b1;
      end
      StDone:  RUN = 1'b1;
      StErr:   ERR = 1'b1;
      default: ;
    endcase
  end

  // Index, length, checksum and registered write port.
  always_comb begin
    idx_d   = idx_q;
    len_d   = len_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (START) begin
          idx_d = '0;
          sum_d = '0;
        end
      end
      StLen: if (xfer) len_d = RX_DATA;
      StData: begin
        if (xfer) begin
          sum_d   = sum_q + RX_DATA;
          idx_d   = idx_q + 8'd1;
          we_d    = 1'b1;
          waddr_d = AddrW'(BASE_ADDR) + AddrW'(idx_q);
          wdata_d = RX_DATA;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      idx_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      idx_q   <= idx_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign WE    = we_q;
  assign WADDR = waddr_q;
  assign WDATA = wdata_q;

endmodule

// File: tb/tb_cpu16_loader.sv
// Directed bench for cpu16_loader: good/bad frames, stalls, reset and START handling.
module tb_cpu16_loader;

  logic        CK = 1'b0;
  logic        RST;
  logic        START;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic        WE;
  logic [15:0] WADDR;
  logic [7:0]  WDATA;
  logic        BUSY;
  logic        RUN;
  logic        ERR;

  int compared   = 0;
  int mismatched = 0;
  int we_cnt     = 0;

  logic [7:0] mem [256];
  // Data bytes sum to 0x92, so 0x6e closes the frame.
  logic [7:0] frame_data [8] = '{8'h01, 8'ha3, 8'h05, 8'h20, 8'h0c, 8'hca, 8'h08, 8'heb};
  localparam logic [7:0] CsumGood = 8'h6e;
  localparam logic [7:0] CsumBad  = 8'h6f;

  cpu16_loader #(
    .MEM_BYTES(64),
    .BASE_ADDR(0)
  ) dut (
    .CK      (CK),
    .RST     (RST),
    .START   (START),
    .RX_DATA (RX_DATA),
    .RX_VALID(RX_VALID),
    .RX_READY(RX_READY),
    .WE      (WE),
    .WADDR   (WADDR),
    .WDATA   (WDATA),
    .BUSY    (BUSY),
    .RUN     (RUN),
    .ERR     (ERR)
  );

  always #5 CK = ~CK;

  // Memory model: performs the write the DUT presents during the ending cycle.
  always @(posedge CK) begin
    if (WE === 1'b1) begin
      mem[WADDR[7:0]] <= WDATA;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic start_load();
    @(negedge CK);
    START = 1'b1;
    @(posedge CK);
    #1 START = 1'b0;
  endtask

  // Offer one byte and hold it until accepted; optional idle cycle afterwards.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    while (RX_READY !== 1'b1 && n < 50) begin
      @(posedge CK);
      #1 n++;
    end
    if (n >= 50) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: RX_READY=%b required 1", RX_READY);
    end
    @(posedge CK);
    #1 RX_VALID = 1'b0;
    if (gap) begin
      @(posedge CK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] csum, input bit gap);
    send_byte(8'h08, gap);
    foreach (frame_data[i]) send_byte(frame_data[i], gap);
    send_byte(csum, gap);
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00;
    #2;
    compared++;
    if ({RX_READY, WE, WADDR, WDATA, BUSY, RUN, ERR} !== 29'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h required 0",
               {RX_READY, WE, WADDR, WDATA, BUSY, RUN, ERR});
    end
    @(negedge CK);
    RST = 1'b0;
    @(posedge CK);
    #1 compared++;
    if ({RX_READY, BUSY, RUN, ERR} !== 4'b0000) begin
      mismatched++;
      $display("FAIL idle_outputs: got %b required 0000", {RX_READY, BUSY, RUN, ERR});
    end
  endtask

  task automatic check_frame_result(input string name, input int base, input bit exp_run);
    compared++;
    if (we_cnt - base !== 8) begin
      mismatched++;
      $display("FAIL %s_we_count: got %0d required 8", name, we_cnt - base);
    end
    compared++;
    if ({RUN, ERR, BUSY, RX_READY} !== {exp_run, ~exp_run, 2'b00}) begin
      mismatched++;
      $display("FAIL %s_status: RUN/ERR/BUSY/RDY got %b required %b", name,
               {RUN, ERR, BUSY, RX_READY}, {exp_run, ~exp_run, 2'b00});
    end
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (mem[i] !== frame_data[i]) begin
        mismatched++;
        $display("FAIL %s_mem[%0d]: got %h required %h", name, i, mem[i], frame_data[i]);
      end
    end
  endtask

  task automatic test_good_frame();
    int base;
    for (int i = 0; i < 8; i++) mem[i] = 8'hxx;
    base = we_cnt;
    start_load();
    compared++;
    if ({BUSY, RX_READY} !== 2'b11) begin
      mismatched++;
      $display("FAIL good_len_ready: got %b required 11", {BUSY, RX_READY});
    end
    send_frame(CsumGood, 1'b0);
    check_frame_result("good", base, 1'b1);
    compared++;
    if ({mem[0], mem[1]} !== 16'h01a3) begin
      mismatched++;
      $display("FAIL good_first_insn: got %h required 01a3", {mem[0], mem[1]});
    end
  endtask

  task automatic test_bad_csum();
    int base = we_cnt;
    start_load();
    send_frame(CsumBad, 1'b0);
    check_frame_result("badcsum", base, 1'b0);
  endtask

  task automatic test_bad_len();
    logic [7:0] lens [3] = '{8'h03, 8'h42, 8'h00};
    foreach (lens[k]) begin
      int base = we_cnt;
      start_load();
      send_byte(lens[k], 1'b0);
      compared++;
      if ({ERR, RUN, BUSY} !== 3'b100) begin
        mismatched++;
        $display("FAIL badlen_%h_status: ERR/RUN/BUSY got %b required 100", lens[k],
                 {ERR, RUN, BUSY});
      end
      @(posedge CK);
      #1 compared++;
      if (we_cnt != base) begin
        mismatched++;
        $display("FAIL badlen_%h_writes: got %0d required 0", lens[k], we_cnt - base);
      end
    end
  endtask

  task automatic test_valid_toggle();
    int base;
    for (int i = 0; i < 8; i++) mem[i] = 8'hxx;
    base = we_cnt;
    start_load();
    send_frame(CsumGood, 1'b1);
    check_frame_result("toggle", base, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    int base;
    start_load();
    send_byte(8'h08, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(frame_data[i], 1'b0);
    compared++;
    if ({WE, WADDR, WDATA} !== {1'b1, 16'd2, 8'h05}) begin
      mismatched++;
      $display("FAIL midrst_third_write: got %b/%h/%h required 1/0002/05", WE, WADDR, WDATA);
    end
    #2 RST = 1'b1;
    #1 compared++;
    if ({RX_READY, WE, WADDR, WDATA, BUSY, RUN, ERR} !== 29'd0) begin
      mismatched++;
      $display("FAIL midrst_outputs: got %h required 0",
               {RX_READY, WE, WADDR, WDATA, BUSY, RUN, ERR});
    end
    @(negedge CK);
    RST = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'hxx;
    base = we_cnt;
    start_load();
    send_frame(CsumGood, 1'b0);
    check_frame_result("midrst", base, 1'b1);
  endtask

  task automatic test_start_ignored();
    int base = we_cnt;
    start_load();
    send_byte(8'h08, 1'b0);
    send_byte(frame_data[0], 1'b0);
    START = 1'b1;
    send_byte(frame_data[1], 1'b0);
    START = 1'b0;
    for (int i = 2; i < 8; i++) send_byte(frame_data[i], 1'b0);
    send_byte(CsumGood, 1'b0);
    check_frame_result("startbusy", base, 1'b1);
    @(negedge CK);
    START = 1'b1;
    compared++;
    if (RUN !== 1'b1) begin
      mismatched++;
      $display("FAIL done_hold_run: got %b required 1", RUN);
    end
    @(posedge CK);
    #1 START = 1'b0;
    compared++;
    if ({RUN, ERR, BUSY, RX_READY} !== 4'b0011) begin
      mismatched++;
      $display("FAIL done_restart: RUN/ERR/BUSY/RDY got %b required 0011",
               {RUN, ERR, BUSY, RX_READY});
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_valid_toggle();
    test_reset_mid_frame();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
